decompress_feeder: RTL and testbench

Upstream stage of the decompression path. It fetches run-length pairs from the compressed region of RAM, presents each pair to the decompress handler as `in1`/`in2` with a `work` strobe, and waits for the handler's completion. It then captures the updated destination byte/bit index and advances to the next pair until the stream ends. It owns the destination write cursor that the handler consumes.

---
 rtl/decompress_feeder.sv | 124 ++++++++++++
 tb/tb_decompress_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_feeder.sv
// Fetches run-length pairs from RAM and feeds them one at a time to the decompress handler.
// Optional DECOMP_FEEDER_EOS_EN: a pair whose run length is zero ends the stream.
module decompress_feeder #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [CNT_W-1:0]  pair_count,
    input  logic [31:0]       dst_byte_init,
    input  logic [2:0]        dst_bit_init,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        in1,
    output logic [7:0]        in2,
    output logic              work,
    output logic [31:0]       byteIndx,
    output logic [2:0]        bitIndx,
    input  logic              hnd_done,
    input  logic [31:0]       newByteIndx,
    input  logic [2:0]        newBitIndx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pairs_done
);

    typedef enum logic [3:0] {
        IDLE, RD1, CAP1, RD2, CAP2, ISSUE, WAIT, GAP, FIN
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            count      <= '0;
            ram_rd     <= 1'b0;
            ram_addr   <= '0;
            in1        <= '0;
            in2        <= '0;
            work       <= 1'b0;
            byteIndx   <= '0;
            bitIndx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pairs_done <= '0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ptr        <= src_base;
                    count      <= pair_count;
                    byteIndx   <= dst_byte_init;
                    bitIndx    <= dst_bit_init;
                    pairs_done <= '0;
                    busy       <= 1'b1;
                    // An empty stream passes through GAP, whose count compare sends it straight to FIN.
                    if (pair_count == '0) begin
                        state <= GAP;
                    end else begin
                        state    <= RD1;
                        ram_rd   <= 1'b1;
                        ram_addr <= src_base;
                    end
                end
                RD1: state <= CAP1;
                CAP1: begin
                    in1      <= ram_rdata;
                    ptr      <= ptr + 1'b1;
                    ram_rd   <= 1'b1;
                    ram_addr <= ptr + 1'b1;
                    state    <= RD2;
                end
                RD2: state <= CAP2;
                CAP2: begin
                    in2 <= ram_rdata;
                    ptr <= ptr + 1'b1;
`ifdef DECOMP_FEEDER_EOS_EN
                    if (ram_rdata == 8'd0) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ISSUE;
                        work  <= 1'b1;
                    end
`else
                    state <= ISSUE;
                    work  <= 1'b1;
`endif
                end
                ISSUE: state <= WAIT;
                WAIT: if (hnd_done) begin
                    byteIndx   <= newByteIndx;
                    bitIndx    <= newBitIndx;
                    pairs_done <= pairs_done + 1'b1;
                    work       <= 1'b0;
                    state      <= GAP;
                end
                GAP: begin
                    if (pairs_done == count) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= RD1;
                        ram_rd   <= 1'b1;
                        ram_addr <= ptr;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_feeder.sv
// Bench for decompress_feeder: vector table of streams, a RAM model, a responding handler and
// scoreboards for read addresses and issued pairs, plus reset / stray-input sequences.
module tb_decompress_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_base = '0;
    logic [15:0] pair_count = '0;
    logic [31:0] dst_byte_init = '0;
    logic [2:0]  dst_bit_init = '0;
    logic        ram_rd;
    logic [15:0] ram_addr;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  in1, in2;
    logic        work;
    logic [31:0] byteIndx;
    logic [2:0]  bitIndx;
    logic        hnd_done = 1'b0;
    logic [31:0] newByteIndx = '0;
    logic [2:0]  newBitIndx = '0;
    logic        busy, done;
    logic [15:0] pairs_done;

    decompress_feeder #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .pair_count(pair_count),
        .dst_byte_init(dst_byte_init), .dst_bit_init(dst_bit_init),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .in1(in1), .in2(in2), .work(work), .byteIndx(byteIndx), .bitIndx(bitIndx),
        .hnd_done(hnd_done), .newByteIndx(newByteIndx), .newBitIndx(newBitIndx),
        .busy(busy), .done(done), .pairs_done(pairs_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0]      src;
        int               cnt;
        logic [3:0][7:0]  b1;
        logic [3:0][7:0]  b2;
        logic [31:0]      byte0;
        logic [2:0]       bit0;
        int               lat;
        logic [31:0]      eb;
        logic [2:0]       ebit;
        int               epd;
    } vec_t;

    typedef struct {
        logic [7:0]  in1;
        logic [7:0]  in2;
        logic [31:0] bi;
        logic [2:0]  bt;
    } pair_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] aq[$];
    pair_t       pq[$];
    int n_chk = 0, n_fail = 0, done_cnt = 0;
    int cur_lat = 2, wcnt = 0, gap = 0;
    bit prev_work = 0, gap_armed = 0, mon_off = 0, inj = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [127:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h want nothing", nm, act);
    endtask

    // RAM: data appears the cycle after the read request
    always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_addr];

    // Handler responder and output monitors
    always @(negedge clk) begin
        int    tot;
        pair_t p;
        hnd_done = inj;
        if (inj) begin
            newByteIndx = 32'hDEAD_BEEF;
            newBitIndx  = 3'd1;
        end
        if (ram_rd && !mon_off) begin
            if (aq.size() == 0) fail_now("rd_extra", ram_addr);
            else chk("rd_addr", ram_addr, aq.pop_front());
        end
        if (work) begin
            if (!prev_work) begin
                if (!mon_off) begin
                    if (pq.size() == 0) fail_now("work_extra", {in1, in2});
                    else begin
                        p = pq.pop_front();
                        chk("pair_in1", in1, p.in1);
                        chk("pair_in2", in2, p.in2);
                        chk("pair_byteIndx", byteIndx, p.bi);
                        chk("pair_bitIndx", bitIndx, p.bt);
                    end
                    if (gap_armed) chk("work_low_between", gap, 5);
                end
                wcnt = 1;
            end else wcnt++;
            if (wcnt == cur_lat) begin
                tot         = int'(bitIndx) + int'(in2);
                hnd_done    = 1'b1;
                newByteIndx = byteIndx + 32'(tot / 8);
                newBitIndx  = 3'(tot % 8);
            end
        end else if (prev_work) begin
            if (!rst && !mon_off) chk("work_high_cycles", wcnt, cur_lat);
            gap_armed = !rst;
            gap = 1;
        end else if (gap_armed) gap++;
        if (done) begin
            done_cnt++;
            gap_armed = 0;
        end
        if (rst) gap_armed = 0;
        prev_work = work;
    end

    function automatic vec_t mk(logic [15:0] s, int c, logic [31:0] b1, logic [31:0] b2,
                                logic [31:0] by, logic [2:0] bt, int l,
                                logic [31:0] eb, logic [2:0] ebt, int ep);
        vec_t v;
        v.src = s; v.cnt = c; v.b1 = b1; v.b2 = b2; v.byte0 = by; v.bit0 = bt;
        v.lat = l; v.eb = eb; v.ebit = ebt; v.epd = ep;
        return v;
    endfunction

    // Push expectations, run one stream to done, check final state and timing.
    task automatic run_vec(input vec_t v, input bit restart);
        logic [31:0] mb;
        logic [2:0]  mbit;
        logic [15:0] a;
        int          t, et, dc0, tot;
        pair_t       p;
        cur_lat = v.lat; mb = v.byte0; mbit = v.bit0; a = v.src; et = 0;
        for (int i = 0; i < v.cnt; i++) begin
            mem[a] = v.b1[i];
            mem[a + 16'd1] = v.b2[i];
            aq.push_back(a);
            aq.push_back(a + 16'd1);
            a = a + 16'd2;
`ifdef DECOMP_FEEDER_EOS_EN
            if (v.b2[i] == 8'd0) begin
                et += 4;
                break;
            end
`endif
            p.in1 = v.b1[i]; p.in2 = v.b2[i]; p.bi = mb; p.bt = mbit;
            pq.push_back(p);
            tot  = int'(mbit) + int'(v.b2[i]);
            mb   = mb + 32'(tot / 8);
            mbit = 3'(tot % 8);
            et  += 5 + v.lat;
        end
        et  = (v.cnt == 0) ? 2 : et + 1;
        dc0 = done_cnt;
        @(negedge clk);
        src_base = v.src; pair_count = 16'(v.cnt);
        dst_byte_init = v.byte0; dst_bit_init = v.bit0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; t = 1;
        chk("busy_rise", busy, 1);
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
            if (restart) begin
                start = (t == 3);
                src_base = 16'hAAAA; pair_count = 16'd7;
            end
        end
        start = 1'b0;
        chk("done_cycle", t, et);
        chk("busy_at_done", busy, 0);
        chk("pairs_done", pairs_done, v.epd);
        chk("final_byteIndx", byteIndx, v.eb);
        chk("final_bitIndx", bitIndx, v.ebit);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("done_count", done_cnt - dc0, 1);
        chk("rd_left", aq.size(), 0);
        chk("pairs_left", pq.size(), 0);
    endtask

    vec_t vt[6];

    initial begin
        int          t, dc0;
        logic [31:0] b0;
        logic [2:0]  bt0;
        logic [15:0] pd0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        vt[0] = mk(16'h0010, 1, 32'h0000_0080, 32'h0000_0005, 32'h100, 3'd0, 4, 32'h100, 3'd5, 1);
        vt[1] = mk(16'h0020, 3, 32'h007F_8000, 32'h000D_0505, 32'h100, 3'd0, 2, 32'h102, 3'd7, 3);
        vt[2] = mk(16'hFFFF, 1, 32'h0000_0080, 32'h0000_0003, 32'h200, 3'd6, 3, 32'h201, 3'd1, 1);
        vt[3] = mk(16'h0040, 0, 32'h0, 32'h0, 32'h300, 3'd2, 2, 32'h300, 3'd2, 0);
        vt[4] = mk(16'h0050, 2, 32'h0000_FF01, 32'h0000_FFC8, 32'hFFFF_FFF0, 3'd7, 5, 32'h29, 3'd6, 2);
`ifdef DECOMP_FEEDER_EOS_EN
        vt[5] = mk(16'h0060, 4, 32'h8080_0080, 32'h0102_0003, 32'h400, 3'd0, 3, 32'h400, 3'd3, 1);
`else
        vt[5] = mk(16'h0060, 4, 32'h8080_0080, 32'h0102_0003, 32'h400, 3'd0, 3, 32'h400, 3'd6, 4);
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ram_rd, work, busy, done, ram_addr, in1, in2, byteIndx, bitIndx, pairs_done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Vector 1 also gets a second start pulse mid-stream, which must be ignored.
        for (int i = 0; i < 6; i++) run_vec(vt[i], i == 1);

        // Stray handler completion while idle
        b0 = byteIndx; bt0 = bitIndx; pd0 = pairs_done;
        inj = 1;
        repeat (3) @(negedge clk);
        inj = 0;
        @(negedge clk);
        chk("idle_hnd_byteIndx", byteIndx, b0);
        chk("idle_hnd_bitIndx", bitIndx, bt0);
        chk("idle_hnd_pairs_done", pairs_done, pd0);
        chk("idle_hnd_busy", busy, 0);

        // Reset while the handler is still working on the first pair
        mon_off = 1; cur_lat = 50;
        src_base = 16'h0020; pair_count = 16'd3; dst_byte_init = 32'h100; dst_bit_init = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; t = 0;
        while (!work && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reach_work", work, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {ram_rd, work, busy, done, ram_addr, in1, in2, byteIndx, bitIndx, pairs_done}, 0);
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (20) @(negedge clk);
        chk("rst_no_done", done_cnt - dc0, 0);
        chk("rst_stays_idle", {ram_rd, work, busy, pairs_done}, 0);
        mon_off = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
